// File: rtl/pipeline_stage_reg.sv
// Single pipeline stage with a one-entry skid buffer, stall/flush control,
// a delayed stall flag and a saturating count of empty output cycles.
module pipeline_stage_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] BUBBLE    = '0,
   parameter int               CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 stall_q,
   output logic [CNT_WIDTH-1:0] bubble_cnt
);

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           r_occ;
   logic [WIDTH-1:0]     r_main;
   logic [WIDTH-1:0]     r_skid;
   logic                 r_stall_q;
   logic [CNT_WIDTH-1:0] r_bubble_cnt;

   logic w_in_ready;
   logic w_out_valid;
   logic w_acc;
   logic w_emit;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // in_ready depends only on local state and stall/flush, never on out_ready
   assign w_in_ready  = (r_occ != OCC_FULL) && !stall && !flush;
   assign w_out_valid = (r_occ != OCC_EMPTY) && !stall;
   assign w_acc       = in_valid && w_in_ready;
   // A flush cycle discards the held entry, so it never counts as a transfer
   assign w_emit      = w_out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ        <= OCC_EMPTY;
         r_main       <= BUBBLE;
         r_skid       <= BUBBLE;
         r_stall_q    <= 1'b0;
         r_bubble_cnt <= '0;
      end else begin
         r_stall_q <= stall;
         if (!w_out_valid)
            r_bubble_cnt <= sat_inc(r_bubble_cnt);

         if (flush) begin
            r_occ  <= OCC_EMPTY;
            r_main <= BUBBLE;
            r_skid <= BUBBLE;
         end else begin
            case (r_occ)
               OCC_EMPTY: begin
                  if (w_acc) begin
                     r_main <= in_data;
                     r_occ  <= OCC_ONE;
                  end
               end
               OCC_ONE: begin
                  if (w_acc && w_emit) begin
                     r_main <= in_data;
                  end else if (w_acc) begin
                     r_skid <= in_data;
                     r_occ  <= OCC_FULL;
                  end else if (w_emit) begin
                     r_main <= BUBBLE;
                     r_occ  <= OCC_EMPTY;
                  end
               end
               OCC_FULL: begin
                  if (w_emit) begin
                     r_main <= r_skid;
                     r_skid <= BUBBLE;
                     r_occ  <= OCC_ONE;
                  end
               end
               default: begin
                  r_occ  <= OCC_EMPTY;
                  r_main <= BUBBLE;
                  r_skid <= BUBBLE;
               end
            endcase
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_out_valid;
   assign out_data   = r_main;
   assign stall_q    = r_stall_q;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: a FIFO-of-depth-2 reference model feeds a
// scoreboard queue; a negedge monitor pops and compares on every emitted entry.
module tb_pipeline_stage_reg;

   localparam int          W   = 32;
   localparam int          CW  = 4;
   localparam logic [31:0] BUB = 32'hDEAD_BEEF;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          stall_q;
   logic [CW-1:0] bubble_cnt;

   pipeline_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_q(stall_q), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  m_bc    = 0;
   logic m_sq   = 1'b0;
   bit  chk_en  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check registered outputs, drive inputs, check
   // combinational outputs, then advance the reference model.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic st, input logic fl, input logic r);
      int  occ;
      logic m_ir, m_ov;
      @(posedge clk); #1;
      if (chk_en) begin
         chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bc));
         chk("stall_q", 64'(stall_q), 64'(m_sq));
         if (exp_q.size() == 0) chk("out_data_empty", 64'(out_data), 64'(BUB));
      end
      in_valid = v; in_data = d; out_ready = ordy; stall = st; flush = fl; rst = r;
      #1;
      occ  = exp_q.size();
      m_ir = (occ < 2) && !st && !fl;
      m_ov = (occ != 0) && !st;
      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(m_ir));
         chk("out_valid", 64'(out_valid), 64'(m_ov));
      end
      if (r || fl) exp_q.delete();
      else if (v && m_ir) exp_q.push_back(d);
      if (r) m_bc = 0;
      else if (!m_ov && m_bc < CNT_MAX) m_bc++;
      m_sq = r ? 1'b0 : st;
      chk_en = 1'b1;
   endtask

   task automatic do_reset();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic fill2(input logic [W-1:0] a, input logic [W-1:0] b);
      cyc(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor: every real transfer must match the oldest accepted entry.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready && !flush && !rst) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_emit: got %0h expected no transfer at %0t", out_data, $time);
         end else begin
            chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      do_reset();
      do_reset();

      // Streaming 1..4 with downstream always ready
      for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Backpressure into the skid register, then drain
      fill2(32'hA, 32'hB);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Stall while full, then release
      fill2(32'h11, 32'h22);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h33, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Flush overrides stall and an offered entry
      fill2(32'h44, 32'h55);
      cyc(1'b1, 32'h66, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset while full and stalled
      fill2(32'h77, 32'h88);
      cyc(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Bubble counter saturation and clear
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      do_reset();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 9) < 6),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 299) == 0));
      end

      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits.
REQ-002 The block SHALL have parameter BUBBLE, default 0, meaning the WIDTH-bit value driven and stored for an empty (bubble) slot.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, meaning the bubble counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream stage offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage can accept this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-009 The block SHALL have port stall, input, 1 bit: freeze the stage, with no transfer in or out.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all held entries.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a real entry.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream takes out_data this cycle.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: oldest held entry, or BUBBLE when empty.
REQ-014 The block SHALL have port stall_q, output, 1 bit: stall delayed by one cycle.
REQ-015 The block SHALL have port bubble_cnt, output, CNT_WIDTH bits: saturating count of cycles with out_valid low.

Function
REQ-016 Storage SHALL be a main register that drives out_data and a skid register, tracked by a state occ in {EMPTY=0, ONE=1, FULL=2}.
REQ-017 in_ready SHALL equal (occ != FULL) AND NOT stall AND NOT flush.
REQ-018 out_valid SHALL equal (occ != EMPTY) AND NOT stall.
REQ-019 out_data SHALL equal the main register, which holds BUBBLE whenever occ = EMPTY.
REQ-020 acc SHALL be defined as in_valid AND in_ready.
REQ-021 emit SHALL be defined as out_valid AND out_ready.
REQ-022 In state EMPTY, acc SHALL load main with in_data and move to ONE.
REQ-023 In state ONE, acc together with emit SHALL load main with in_data and stay in ONE.
REQ-024 In state ONE, acc without emit SHALL load skid with in_data and move to FULL.
REQ-025 In state ONE, emit without acc SHALL set main to BUBBLE and move to EMPTY.
REQ-026 In state FULL, emit SHALL move skid into main, set skid to BUBBLE and move to ONE; acc is impossible in FULL.
REQ-027 With neither acc nor emit, all storage and occ SHALL hold.
REQ-028 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush or rst.
REQ-029 Latency SHALL be 1 cycle: data accepted in cycle N appears on out_data in cycle N+1 when occ was EMPTY, or when occ was ONE with emit in cycle N.
REQ-030 While stall is high (and flush is low), occ, main and skid SHALL hold, and in_ready and out_valid SHALL be 0.
REQ-031 flush SHALL override stall and handshakes: on the next edge occ becomes EMPTY and main and skid become BUBBLE, and no acc or emit occurs in the flush cycle.
REQ-032 stall_q SHALL register stall every cycle, independent of flush.
REQ-033 bubble_cnt SHALL increment by 1 on each edge where out_valid was 0, and SHALL saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-034 in_ready SHALL have no combinational path from out_ready.

Reset
REQ-035 When rst is high at an edge, occ SHALL become EMPTY, main and skid BUBBLE, stall_q 0 and bubble_cnt 0, overriding stall and flush.
REQ-036 During the rst cycle, in_ready and out_valid SHALL follow REQ-017 and REQ-018 from the current state; after the reset edge, in_ready is 1 unless stall or flush is high.
REQ-037 Reset mid-operation SHALL discard held entries without emitting them.

Verification
REQ-038 Streaming: after reset, apply in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data reads 1,2,3,4 one cycle later each, and occ never reaches FULL.
REQ-039 Backpressure: with occ=ONE holding 0xA, out_ready=0, offer 0xB -> occ=FULL and in_ready=0; then out_ready=1 -> out_data reads 0xA, then 0xB, then BUBBLE.
REQ-040 Stall: with occ=FULL, assert stall for 3 cycles with out_ready=1 -> in_ready=0, out_valid=0, data unchanged, and stall_q high one cycle delayed; release -> both entries emitted in order.
REQ-041 Flush: with occ=FULL, assert flush together with stall and in_valid=1 -> the next cycle has occ=EMPTY, out_data=BUBBLE and out_valid=0, and the offered data is not accepted.
REQ-042 Counter: with CNT_WIDTH=4, hold the stage empty for 20 cycles -> bubble_cnt reaches 15 and stays there; apply rst -> bubble_cnt = 0.
REQ-043 Reset mid-operation: with occ=FULL, assert rst together with flush=0 and stall=1 -> the next cycle has occ=EMPTY, stall_q=0 and out_data=BUBBLE.
